fc_layer_par: RTL and testbench

FC_LAYER_PAR -- requirements
Module: fc_layer_par

---
 rtl/fc_layer_par.sv | 130 +++++++++++++
 tb/tb_fc_layer_par.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fc_layer_par.sv
// Fully-connected layer: N_OUT neurons accumulate one streamed activation per cycle in parallel,
// then drain biased, scaled, activated and saturated results one neuron at a time.
module fc_layer_par #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 16,
    parameter int N_IN      = 4,
    parameter int N_OUT     = 4,
    parameter int FRAC      = 8,
    parameter int RELU      = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic signed [WIDTH_IN-1:0]             data_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    output logic signed [WIDTH_OUT-1:0]            data_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    input  logic                                   wt_we_i,
    input  logic [$clog2(N_IN*N_OUT+N_OUT)-1:0]    wt_addr_i,
    input  logic [WIDTH_IN-1:0]                    wt_data_i,
    output logic                                   busy_o
);
    localparam int ADDR_W = $clog2(N_IN*N_OUT+N_OUT);
    localparam int ACC_W  = 2*WIDTH_IN + $clog2(N_IN) + 1;
    localparam int SUM_W  = ACC_W + FRAC + 1;
    localparam int K_W    = $clog2(N_IN);
    localparam int J_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_IN-1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT-1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (WIDTH_OUT-1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {S_ACCUM, S_DRAIN} state_t;

    state_t                      r_state, w_state_nxt;
    logic                        r_live;
    logic [K_W-1:0]              r_k;
    logic [J_W-1:0]              r_j;
    logic signed [ACC_W-1:0]     r_acc [N_OUT];
    logic signed [WIDTH_IN-1:0]  r_w   [N_OUT][N_IN];
    logic signed [WIDTH_IN-1:0]  r_b   [N_OUT];
    logic signed [2*WIDTH_IN-1:0] w_prod [N_OUT];
    logic                        w_in_fire, w_out_fire;
    logic signed [SUM_W-1:0]     w_sum, w_shr, w_act, w_sat;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= S_ACCUM;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        valid_o     = 1'b0;
        w_in_fire   = 1'b0;
        w_out_fire  = 1'b0;
        case (r_state)
            S_ACCUM: begin
                ready_o   = r_live;
                w_in_fire = valid_i && r_live;
                if (w_in_fire && r_k == K_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                valid_o    = 1'b1;
                w_out_fire = ready_i;
                if (ready_i && r_j == J_LAST) w_state_nxt = S_ACCUM;
            end
            default: w_state_nxt = S_ACCUM;
        endcase
        busy_o = (r_k != '0) || (r_state == S_DRAIN);
    end

    always_comb begin
        for (int unsigned o = 0; o < N_OUT; o++)
            w_prod[o] = (2*WIDTH_IN)'(data_i) * (2*WIDTH_IN)'(r_w[o][r_k]);
    end

    // r_live holds ready_o low until the first edge after reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_live <= 1'b0;
            r_k    <= '0;
            r_j    <= '0;
            for (int unsigned o = 0; o < N_OUT; o++) r_acc[o] <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_in_fire) begin
                for (int unsigned o = 0; o < N_OUT; o++)
                    r_acc[o] <= r_acc[o] + ACC_W'(w_prod[o]);
                r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
            end
            if (w_out_fire) begin
                if (r_j == J_LAST) begin
                    r_j <= '0;
                    for (int unsigned o = 0; o < N_OUT; o++) r_acc[o] <= '0;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

    // Address decode by comparison, so addresses beyond the last bias match nothing.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned o = 0; o < N_OUT; o++) begin
                r_b[o] <= '0;
                for (int unsigned i = 0; i < N_IN; i++) r_w[o][i] <= '0;
            end
        end else if (wt_we_i && !busy_o) begin
            for (int unsigned o = 0; o < N_OUT; o++) begin
                if (wt_addr_i == ADDR_W'(N_IN*N_OUT + o)) r_b[o] <= wt_data_i;
                for (int unsigned i = 0; i < N_IN; i++)
                    if (wt_addr_i == ADDR_W'(o*N_IN + i)) r_w[o][i] <= wt_data_i;
            end
        end
    end

    always_comb begin
        w_sum = SUM_W'(r_acc[r_j]) + (SUM_W'(r_b[r_j]) <<< FRAC);
        w_shr = w_sum >>> FRAC;
        if (RELU != 0 && w_shr[SUM_W-1]) w_act = '0;
        else                             w_act = w_shr;
        if (w_act > SAT_MAX)      w_sat = SAT_MAX;
        else if (w_act < SAT_MIN) w_sat = SAT_MIN;
        else                      w_sat = w_act;
        data_o = (r_state == S_DRAIN) ? WIDTH_OUT'(w_sat) : '0;
    end
endmodule

// File: tb/tb_fc_layer_par.sv
// Directed bench for fc_layer_par: a ReLU and a linear instance share stimulus and handshakes.
module tb_fc_layer_par;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [7:0] data_i = '0;
    logic              valid_i = 1'b0, ready_i = 1'b0, wt_we = 1'b0;
    logic [2:0]        wt_addr = '0;
    logic [7:0]        wt_data = '0;
    logic              rdy_r, vld_r, busy_r, rdy_l, vld_l, busy_l;
    logic signed [7:0] dout_r, dout_l;
    int                n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    fc_layer_par #(.WIDTH_IN(8), .WIDTH_OUT(8), .N_IN(2), .N_OUT(2), .FRAC(0), .RELU(1)) u_relu (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(rdy_r),
        .data_o(dout_r), .valid_o(vld_r), .ready_i(ready_i), .wt_we_i(wt_we),
        .wt_addr_i(wt_addr), .wt_data_i(wt_data), .busy_o(busy_r));

    fc_layer_par #(.WIDTH_IN(8), .WIDTH_OUT(8), .N_IN(2), .N_OUT(2), .FRAC(0), .RELU(0)) u_lin (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(rdy_l),
        .data_o(dout_l), .valid_o(vld_l), .ready_i(ready_i), .wt_we_i(wt_we),
        .wt_addr_i(wt_addr), .wt_data_i(wt_data), .busy_o(busy_l));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic wr(input logic [2:0] a, input int d);
        wt_we = 1'b1; wt_addr = a; wt_data = 8'(d);
        @(negedge clk);
        wt_we = 1'b0;
    endtask

    task automatic send(input int x);
        int cnt = 0;
        while (!rdy_r && cnt < 50) begin @(negedge clk); cnt++; end
        if (cnt >= 50) chk("send_timeout", 0, 1);
        valid_i = 1'b1; data_i = 8'(x);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic recv(input string tag, input int e_relu, input int e_lin);
        int cnt = 0;
        while (!vld_r && cnt < 50) begin @(negedge clk); cnt++; end
        chk({tag, "_valid"}, int'(vld_r && vld_l), 1);
        chk({tag, "_relu"}, int'(dout_r), e_relu);
        chk({tag, "_lin"}, int'(dout_l), e_lin);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic frame(input string tag, input int a, input int b,
                         input int r0, input int l0, input int r1, input int l1);
        send(a);
        send(b);
        recv({tag, "0"}, r0, l0);
        recv({tag, "1"}, r1, l1);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst_ready", int'(rdy_r), 0);
        chk("rst_valid", int'(vld_r), 0);
        chk("rst_busy", int'(busy_r), 0);
        chk("rst_data", int'(dout_l), 0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", int'(rdy_r), 0);
        @(negedge clk);
        chk("ready_after_edge", int'(rdy_r), 1);

        wr(0, 1); wr(1, 2); wr(2, -1); wr(3, 1); wr(4, 0); wr(5, 5);

        send(3);
        chk("A_busy_k1", int'(busy_r), 1);
        chk("A_valid_early", int'(vld_r), 0);
        send(4);
        chk("A_valid_latency", int'(vld_r), 1);
        chk("A_ready_drain", int'(rdy_r), 0);
        valid_i = 1'b1; data_i = 8'sd3;
        for (int c = 0; c < 5; c++) begin
            chk("stall_data", int'(dout_r), 11);
            chk("stall_valid", int'(vld_r), 1);
            chk("stall_ready", int'(rdy_r), 0);
            @(negedge clk);
        end
        recv("A0", 11, 11);
        chk("A_ready_mid_drain", int'(rdy_r), 0);
        recv("A1", 6, 6);
        chk("A_ready_after", int'(rdy_r), 1);
        chk("A_busy_after", int'(busy_r), 0);
        @(negedge clk);
        valid_i = 1'b0;
        chk("B_busy_k1", int'(busy_r), 1);
        wr(0, 9);
        send(4);
        recv("B0", 11, 11);
        recv("B1", 6, 6);

        wr(0, 9);
        send(3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("C_idle_busy", int'(busy_r), 1);
            chk("C_idle_valid", int'(vld_r), 0);
        end
        send(4);
        recv("C0", 35, 35);
        recv("C1", 6, 6);

        wr(0, 1); wr(5, -10);
        frame("D", 3, 4, 11, 11, 0, -9);

        wr(0, 127); wr(1, 127); wr(2, 127); wr(3, 127); wr(4, 0); wr(5, 0);
        frame("SATP", 127, 127, 127, 127, 127, 127);
        frame("SATN", -128, -128, 0, -128, 0, -128);

        send(1);
        send(1);
        recv("E0", 127, 127);
        rst_n = 1'b0;
        #1;
        chk("E_rst_valid", int'(vld_r), 0);
        chk("E_rst_ready", int'(rdy_r), 0);
        chk("E_rst_busy", int'(busy_r), 0);
        chk("E_rst_data", int'(dout_r), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("E_no_partial", int'(vld_r), 0);
        frame("F", 1, 1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
